// File: rtl/tcam_lookup_ctrl.sv
// Client-side controller for a TCAM. It sequences single writes and searches, and holds each
// search result until the client takes it. It also keeps saturating hit and miss counters.
module tcam_lookup_ctrl #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int LAT    = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_found_o,
    output logic [ADDR_W-1:0] rsp_addr_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              tcam_we_o,
    output logic [ADDR_W-1:0] tcam_waddr_o,
    output logic [DATA_W-1:0] tcam_data_o,
    output logic              tcam_search_o,
    input  logic [ADDR_W-1:0] tcam_saddr_i,
    input  logic [DATA_W-1:0] tcam_sdata_i,
    input  logic              tcam_found_i,
    output logic [CNT_W-1:0]  hit_count_o,
    output logic [CNT_W-1:0]  miss_count_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_SRCH, ST_RESP} state_e;

    localparam int                LCNT_W    = (LAT < 1) ? 1 : $clog2(LAT + 1);
    localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LAT);
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
    logic                found_q, found_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]    hit_q, hit_d;
    logic [CNT_W-1:0]    miss_q, miss_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            lcnt_q  <= '0;
            found_q <= 1'b0;
            raddr_q <= '0;
            rdata_q <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            lcnt_q  <= lcnt_d;
            found_q <= found_d;
            raddr_q <= raddr_d;
            rdata_q <= rdata_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        lcnt_d  = lcnt_q;
        found_d = found_q;
        raddr_d = raddr_q;
        rdata_d = rdata_q;
        hit_d   = hit_q;
        miss_d  = miss_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    data_d  = req_data_i;
                    lcnt_d  = '0;
                    state_d = req_write_i ? ST_WR : ST_SRCH;
                end
            end
            ST_WR: state_d = ST_IDLE;
            ST_SRCH: begin
                // The TCAM result is valid only on the last search cycle; a miss reports zeros.
                if (lcnt_q == LCNT_LAST) begin
                    found_d = tcam_found_i;
                    raddr_d = tcam_found_i ? tcam_saddr_i : '0;
                    rdata_d = tcam_found_i ? tcam_sdata_i : '0;
                    if (tcam_found_i) begin
                        if (hit_q != '1) hit_d = hit_q + CNT_W'(1);
                    end else begin
                        if (miss_q != '1) miss_d = miss_q + CNT_W'(1);
                    end
                    state_d = ST_RESP;
                end else begin
                    lcnt_d = lcnt_q + LCNT_W'(1);
                end
            end
            ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o   = (state_q == ST_IDLE) && rst_ni;
        tcam_we_o     = (state_q == ST_WR) && ({1'b0, addr_q} < DEPTH_L);
        tcam_waddr_o  = (state_q == ST_WR) ? addr_q : '0;
        tcam_data_o   = ((state_q == ST_WR) || (state_q == ST_SRCH)) ? data_q : '0;
        tcam_search_o = (state_q == ST_SRCH);
        rsp_valid_o   = (state_q == ST_RESP);
        rsp_found_o   = found_q;
        rsp_addr_o    = raddr_q;
        rsp_data_o    = rdata_q;
        hit_count_o   = hit_q;
        miss_count_o  = miss_q;
    end

endmodule

// File: tb/tb_tcam_lookup_ctrl.sv
// Randomised bench for tcam_lookup_ctrl. It contains a ternary-CAM environment model and a
// transaction-level reference that gives the expected outputs on every cycle.
module tb_tcam_lookup_ctrl;
    localparam int DATA_W  = 16;
    localparam int DEPTH   = 10;
    localparam int ADDR_W  = 4;
    localparam int LAT     = 1;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0, rst_n = 1'b1;
    logic req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_data = '0, req_mask = '1;
    logic req_ready, rsp_valid, rsp_found, tcam_we, tcam_search, tcam_found;
    logic [ADDR_W-1:0] rsp_addr, tcam_waddr, tcam_saddr;
    logic [DATA_W-1:0] rsp_data, tcam_data, tcam_sdata;
    logic [CNT_W-1:0]  hit_count, miss_count;

    int n_checks = 0, n_err = 0;
    logic chk_en = 1'b0, rsp_rand = 1'b0, rsp_man = 1'b1;

    always #5 clk = ~clk;

    tcam_lookup_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_found_o(rsp_found),
        .rsp_addr_o(rsp_addr), .rsp_data_o(rsp_data),
        .tcam_we_o(tcam_we), .tcam_waddr_o(tcam_waddr), .tcam_data_o(tcam_data),
        .tcam_search_o(tcam_search), .tcam_saddr_i(tcam_saddr), .tcam_sdata_i(tcam_sdata),
        .tcam_found_i(tcam_found), .hit_count_o(hit_count), .miss_count_o(miss_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Ternary CAM contents: value, care mask (1 = compare) and valid flag.
    logic [DATA_W-1:0] tval [16];
    logic [DATA_W-1:0] tmsk [16];
    logic              tvld [16];
    logic              pf [LAT];
    logic [ADDR_W-1:0] pa [LAT];
    logic [DATA_W-1:0] pd [LAT];
    assign tcam_found = pf[LAT-1];
    assign tcam_saddr = pa[LAT-1];
    assign tcam_sdata = pd[LAT-1];

    initial begin
        for (int i = 0; i < 16; i++) begin
            tval[i] = '0; tmsk[i] = '1; tvld[i] = 1'b0;
        end
        for (int i = 0; i < LAT; i++) begin
            pf[i] = 1'b0; pa[i] = '0; pd[i] = '0;
        end
    end

    // The lowest-indexed matching entry wins.
    function automatic void lookup(input logic [DATA_W-1:0] key, output logic f,
                                   output logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
        f = 1'b0; a = '0; d = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (tvld[i] && (((key ^ tval[i]) & tmsk[i]) == '0)) begin
                f = 1'b1; a = ADDR_W'(i); d = tval[i];
            end
    endfunction

    // Reference: the transaction in progress, given by its kind and its accept-edge number.
    int cyc = 0, m_acc = 0, m_kind = 0;            // kind 0 none, 1 write, 2 search
    int m_hit = 0, m_miss = 0;
    logic [ADDR_W-1:0] m_addr = '0, m_a = '0, la;
    logic [DATA_W-1:0] m_data = '0, m_mask = '1, m_d = '0, ld;
    logic m_f = 1'b0, lf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_kind = 0; m_hit = 0; m_miss = 0;
        end else begin
            if (tcam_we && int'(tcam_waddr) < DEPTH) begin
                tval[tcam_waddr] = tcam_data; tmsk[tcam_waddr] = m_mask; tvld[tcam_waddr] = 1'b1;
            end
            lookup(tcam_data, lf, la, ld);
            for (int i = LAT - 1; i > 0; i--) begin
                pf[i] <= pf[i-1]; pa[i] <= pa[i-1]; pd[i] <= pd[i-1];
            end
            pf[0] <= tcam_search ? lf : 1'($urandom);
            pa[0] <= (tcam_search && lf) ? la : ADDR_W'($urandom);
            pd[0] <= (tcam_search && lf) ? ld : DATA_W'($urandom);
            cyc++;
            if (m_kind == 0) begin
                if (req_valid) begin
                    m_acc = cyc; m_addr = req_addr; m_data = req_data; m_mask = req_mask;
                    m_kind = req_write ? 1 : 2;
                    if (!req_write) lookup(req_data, m_f, m_a, m_d);
                end
            end else if (m_kind == 1) begin
                if (cyc == m_acc + 1) m_kind = 0;
            end else begin
                if (cyc == m_acc + LAT + 1) begin
                    if (m_f) m_hit = (m_hit < CNT_MAX) ? m_hit + 1 : m_hit;
                    else     m_miss = (m_miss < CNT_MAX) ? m_miss + 1 : m_miss;
                end
                if (cyc >= m_acc + LAT + 2 && rsp_ready) m_kind = 0;
            end
        end
    end

    logic e_srch, e_rv, e_we;
    always @(negedge clk) begin
        if (chk_en) begin
            e_we   = (m_kind == 1) && (int'(m_addr) < DEPTH);
            e_srch = (m_kind == 2) && (cyc <= m_acc + LAT);
            e_rv   = (m_kind == 2) && (cyc > m_acc + LAT);
            chk("req_ready", req_ready, rst_n && m_kind == 0);
            chk("tcam_we", tcam_we, e_we);
            chk("tcam_search", tcam_search, e_srch);
            chk("we_search_excl", tcam_we & tcam_search, 0);
            chk("rsp_valid", rsp_valid, e_rv);
            chk("tcam_data", tcam_data, (m_kind == 1 || e_srch) ? m_data : '0);
            if (m_kind != 2) chk("tcam_waddr", tcam_waddr, (m_kind == 1) ? m_addr : '0);
            if (e_rv) begin
                chk("rsp_found", rsp_found, m_f);
                chk("rsp_addr", rsp_addr, m_a);
                chk("rsp_data", rsp_data, m_d);
            end
            chk("hit_count", hit_count, m_hit);
            chk("miss_count", miss_count, m_miss);
        end
    end

    initial forever begin
        @(posedge clk); #1;
        rsp_ready = rsp_rand ? 1'($urandom) : rsp_man;
    end

    task automatic send(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [DATA_W-1:0] msk);
        logic r;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_data = d; req_mask = msk;
        for (int i = 0; ; i++) begin
            @(negedge clk); r = req_ready;
            @(posedge clk);
            if (r) break;
            if (i == 300) begin chk("req_accept_timeout", 0, 1); break; end
        end
        #1;
        req_valid = 1'b0; req_write = 1'($urandom);
        req_addr = ADDR_W'($urandom); req_data = DATA_W'($urandom);
        $display("req %s addr=%0d data=%04h mask=%04h", wr ? "WR" : "SRCH", a, d, msk);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); n++;
            if (rsp_valid) begin
                $display("rsp found=%0d addr=%0d data=%04h", rsp_found, rsp_addr, rsp_data);
                return;
            end
        end
        chk("rsp_timeout", 0, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int idx;
        logic [DATA_W-1:0] key, msk;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_hit", hit_count, 0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", req_ready, 1);

        // Write, then search the same key.
        send(1'b1, 4'd1, 16'b1111110010000000, '1);
        @(negedge clk); chk("t1_we_on", tcam_we, 1);
        @(negedge clk); chk("t1_we_off", tcam_we, 0);
        send(1'b0, 4'd0, 16'b1111110010000000, '1);
        wait_rsp(n);
        chk("t1_latency", n, 3);
        chk("t1_found", rsp_found, 1);
        chk("t1_addr", rsp_addr, 1);
        chk("t1_data", rsp_data, 16'b1111110010000000);
        chk("t1_hits", hit_count, 1);

        // Entry with a don't-care bit at position 13, followed by a miss.
        send(1'b1, 4'd0, 16'b0000101010000011, 16'hDFFF);
        send(1'b0, 4'd0, 16'b0010101010000011, '1);
        wait_rsp(n);
        chk("t2_found", rsp_found, 1);
        chk("t2_addr", rsp_addr, 0);
        send(1'b0, 4'd0, 16'b1100101010110101, '1);
        wait_rsp(n);
        chk("t2_miss_found", rsp_found, 0);
        chk("t2_miss_addr", rsp_addr, 0);
        chk("t2_miss_data", rsp_data, 0);
        chk("t2_miss_count", miss_count, 1);

        // Response held off by rsp_ready for four cycles.
        rsp_man = 1'b0;
        send(1'b0, 4'd0, 16'b1111110010000000, '1);
        wait_rsp(n);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", rsp_valid, 1);
            chk("t3_hold_addr", rsp_addr, 1);
            chk("t3_hold_ready", req_ready, 0);
        end
        rsp_man = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); chk("t3_still_valid", rsp_valid, 1);
        @(negedge clk); chk("t3_back_idle", req_ready, 1);
        chk("t3_hits_sat", hit_count, 3);

        // A write beyond DEPTH is dropped but still lasts one cycle.
        send(1'b1, 4'd12, 16'h1234, '1);
        @(negedge clk); chk("t4_no_we", tcam_we, 0); chk("t4_busy", req_ready, 0);
        @(negedge clk); chk("t4_ready_back", req_ready, 1);
        send(1'b0, 4'd0, 16'h1234, '1);
        wait_rsp(n);
        chk("t4_miss", rsp_found, 0);

        // Asynchronous reset in the middle of a search.
        send(1'b0, 4'd0, 16'b1111110010000000, '1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_search_drop", tcam_search, 0);
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_hits", hit_count, 0);
        chk("t5_misses", miss_count, 0);
        @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
        repeat (4) begin @(negedge clk); chk("t5_no_rsp", rsp_valid, 0); end
        send(1'b0, 4'd0, 16'b1111110010000000, '1);
        wait_rsp(n);
        chk("t5_after_found", rsp_found, 1);
        chk("t5_after_hits", hit_count, 1);

        // Five write/search hit pairs saturate the 2-bit hit counter.
        for (int k = 0; k < 5; k++) begin
            send(1'b1, ADDR_W'(k + 2), DATA_W'(16'h1000 + k * 16'h0111), '1);
            send(1'b0, 4'd0, DATA_W'(16'h1000 + k * 16'h0111), '1);
            wait_rsp(n);
            chk("t6_addr", rsp_addr, k + 2);
        end
        @(negedge clk);
        chk("t6_hits", hit_count, 3);
        chk("t6_misses", miss_count, 0);

        // Random traffic with random rsp_ready and occasional resets.
        rsp_rand = 1'b1;
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 59) == 0) begin
                @(posedge clk); #3 rst_n = 1'b0;
                @(posedge clk); #3 rst_n = 1'b1;
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            if ($urandom_range(0, 9) < 4) begin
                msk = ($urandom_range(0, 2) == 0) ? (DATA_W'($urandom) | DATA_W'($urandom)) : '1;
                send(1'b1, ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom), msk);
            end else begin
                idx = $urandom_range(0, DEPTH - 1);
                if ($urandom_range(0, 1) == 0 && tvld[idx])
                    key = tval[idx] ^ (DATA_W'($urandom) & ~tmsk[idx]);
                else
                    key = DATA_W'($urandom);
                send(1'b0, ADDR_W'($urandom), key, '1);
            end
        end
        repeat (20) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
